// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
//   Shared types and constants for the memory port B arbiter.
//
//   Contents:
//     arb_state_t  - arbiter FSM state (idle / read-data wait)
//     req_id_t     - requester index
//     REQ_CPU, REQ_LOADER, REQ_VGA - requester indices
//     req_onehot() - converts a requester index to a one-hot vector
// ---------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_RD_WAIT} arb_state_t;

  typedef logic [1:0] req_id_t;

  localparam int      NUM_REQ    = 3;
  localparam req_id_t REQ_CPU    = 2'd0;
  localparam req_id_t REQ_LOADER = 2'd1;
  localparam req_id_t REQ_VGA    = 2'd2;

  function automatic logic [NUM_REQ-1:0] req_onehot(input req_id_t id);
    return 3'b001 << id;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
//   Purely combinational winner selection for the port B arbiter.
//
//   Ports:
//     valid  in  [2:0] - per-requester request
//     starve in  1     - R2 has waited long enough to jump ahead of R0
//     rr_ptr in  1     - 1: R2 is preferred over R1, 0: R1 is preferred
//     grant  out [2:0] - one-hot winner (all zero when nobody requests)
//     id     out       - index of the winner (REQ_CPU when nobody requests)
//
//   Priority: starved R2, then R0, then R1/R2 ordered by rr_ptr. A fixed
//   priority build simply ties rr_ptr low.
// ---------------------------------------------------------------------------
module arb_pick
  import arb_pkg::*;
(
  input  logic [2:0] valid,
  input  logic       starve,
  input  logic       rr_ptr,
  output logic [2:0] grant,
  output req_id_t    id
);

  always_comb begin
    grant = '0;
    id    = REQ_CPU;
    if (valid[REQ_VGA] && starve) begin
      id = REQ_VGA;
    end else if (valid[REQ_CPU]) begin
      id = REQ_CPU;
    end else if (valid[REQ_LOADER] && valid[REQ_VGA]) begin
      id = rr_ptr ? REQ_VGA : REQ_LOADER;
    end else if (valid[REQ_LOADER]) begin
      id = REQ_LOADER;
    end else if (valid[REQ_VGA]) begin
      id = REQ_VGA;
    end
    if (valid != '0) begin
      grant = req_onehot(id);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares port B of the unified instruction/data memory between the CPU
//   load/store unit (R0), the UART program loader (R1) and the VGA/debug
//   reader (R2). One access is accepted per idle slot; a read then spends
//   one cycle in RD_WAIT while the BRAM produces its data.
//
//   Parameters:
//     STARVE_LIMIT - cycles R2 may wait before it outranks R0
//     CNT_W        - starvation counter width, 2**CNT_W must exceed STARVE_LIMIT
//
//   Ports:
//     clk, reset          - clock, synchronous active-high reset
//     req_valid/req_we    - per-requester request and write flag
//     req_addr/req_wdata  - per-requester byte address and write data
//     req_ready           - one-hot combinational accept
//     rsp_valid/rsp_rdata - one-hot read response and shared read data
//     mem_addr/mem_wdata/mem_we/mem_rdata - memory port B
//     cpu_stall           - R0 waiting for accept or for its read data
//
//   Build option:
//     ARB_ROUND_ROBIN_EN - when defined, R1 and R2 alternate through a
//                          last-grant pointer; otherwise R1 beats R2.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 15,
  parameter int CNT_W        = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req_valid,
  input  logic [2:0]      req_we,
  input  logic [2:0][31:0] req_addr,
  input  logic [2:0][31:0] req_wdata,
  output logic [2:0]      req_ready,
  output logic [2:0]      rsp_valid,
  output logic [31:0]     rsp_rdata,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  output logic            mem_we,
  input  logic [31:0]     mem_rdata,
  output logic            cpu_stall
);

  arb_state_t       state_q, state_d;
  req_id_t          id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             starve;
  logic             rr_ptr;
  logic [2:0]       pick_grant;
  req_id_t          pick_id;

  assign starve = (cnt_q == CNT_W'(STARVE_LIMIT));

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr_q, rr_ptr_d;

  // Pointer remembers which of R1/R2 went last so the other one is favoured;
  // grants to R0 leave it untouched. Reset favours R1.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (req_ready[REQ_LOADER]) begin
      rr_ptr_d = 1'b1;
    end else if (req_ready[REQ_VGA]) begin
      rr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = 1'b0;
`endif

  arb_pick u_pick (
    .valid  (req_valid),
    .starve (starve),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .id     (pick_id)
  );

  // FSM next state and port outputs. The memory address and write data are
  // held from the last granted access whenever nothing is accepted, which
  // also keeps the reading requester's address on the port during RD_WAIT.
  // While reset is high every output is forced to zero so nothing is
  // accepted or returned in the reset cycle itself.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    rdata_d   = rdata_q;
    req_ready = '0;
    rsp_valid = '0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    rsp_rdata = rdata_q;

    if (state_q == ARB_IDLE) begin
      if (pick_grant != '0) begin
        req_ready = pick_grant;
        mem_we    = req_we[pick_id];
        mem_addr  = req_addr[pick_id];
        mem_wdata = req_wdata[pick_id];
        if (!req_we[pick_id]) begin
          state_d = ARB_RD_WAIT;
          id_d    = pick_id;
        end
      end
    end else begin
      rsp_valid = req_onehot(id_q);
      rsp_rdata = mem_rdata;
      rdata_d   = mem_rdata;
      state_d   = ARB_IDLE;
    end

    addr_d  = mem_addr;
    wdata_d = mem_wdata;

    cpu_stall = (req_valid[REQ_CPU] && !req_ready[REQ_CPU]) ||
                (state_q == ARB_RD_WAIT && id_q == REQ_CPU);

    if (reset) begin
      req_ready = '0;
      rsp_valid = '0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      rsp_rdata = '0;
      cpu_stall = 1'b0;
    end
  end

  // R2 starvation counter: counts every cycle R2 waits, RD_WAIT included,
  // and saturates so promotion stays armed until R2 is served.
  always_comb begin
    cnt_d = cnt_q;
    if (!req_valid[REQ_VGA] || req_ready[REQ_VGA]) begin
      cnt_d = '0;
    end else if (!starve) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      id_q    <= REQ_CPU;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed and randomized stimulus for mem_port_arbiter. Every cycle the
//   outputs are compared against a reference model that tracks requests
//   as plain priority rules, a queue of outstanding reads and a wait count.
//   Build option ARB_ROUND_ROBIN_EN selects the matching model behaviour.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       req_valid;
  logic [2:0]       req_we;
  logic [2:0][31:0] req_addr;
  logic [2:0][31:0] req_wdata;
  logic [2:0]       req_ready;
  logic [2:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_we;
  logic [31:0]      mem_rdata;
  logic             cpu_stall;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .cpu_stall (cpu_stall)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          wait2;
  int          favour;
  int          pend_q[$];
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  logic [2:0]  exp_ready;
  bit          hold [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Predict this cycle's outputs from the current inputs, compare, then
  // advance the model as the posedge will.
  task automatic check_output();
    logic [2:0]  e_ready;
    logic [2:0]  e_rsp;
    logic        e_we;
    logic        e_stall;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    int          win;
    bit          reading;
    win     = -1;
    reading = (pend_q.size() != 0);
    e_ready = '0;
    e_rsp   = '0;
    e_we    = 1'b0;
    e_addr  = last_addr;
    e_wdata = last_wdata;
    e_rdata = mem_rdata;
    if (!reading) begin
      if (req_valid[2] && wait2 >= STARVE_LIMIT) win = 2;
      else if (req_valid[0]) win = 0;
      else if (req_valid[1] && req_valid[2]) win = favour;
      else if (req_valid[1]) win = 1;
      else if (req_valid[2]) win = 2;
    end
    if (win >= 0) begin
      e_ready[win] = 1'b1;
      e_we    = req_we[win];
      e_addr  = req_addr[win];
      e_wdata = req_wdata[win];
    end
    if (reading) e_rsp[pend_q[0]] = 1'b1;
    e_stall = (req_valid[0] && !e_ready[0]) || (reading && pend_q[0] == 0);
    if (reset) begin
      win = -1; e_ready = '0; e_rsp = '0; e_we = 1'b0; e_stall = 1'b0;
      e_addr = '0; e_wdata = '0; e_rdata = '0;
    end

    check("req_ready", {29'd0, req_ready}, {29'd0, e_ready});
    check("rsp_valid", {29'd0, rsp_valid}, {29'd0, e_rsp});
    check("mem_we", {31'd0, mem_we}, {31'd0, e_we});
    check("mem_addr", mem_addr, e_addr);
    check("cpu_stall", {31'd0, cpu_stall}, {31'd0, e_stall});
    if (reset || win >= 0) check("mem_wdata", mem_wdata, e_wdata);
    if (reset || reading) check("rsp_rdata", rsp_rdata, e_rdata);

    if (reset) begin
      pend_q.delete();
      wait2 = 0; favour = 1; last_addr = '0; last_wdata = '0;
    end else begin
      if (req_valid[2] && !e_ready[2]) wait2++;
      else wait2 = 0;
      if (reading) void'(pend_q.pop_front());
      if (win >= 0) begin
        last_addr  = e_addr;
        last_wdata = e_wdata;
        if (!req_we[win]) pend_q.push_back(win);
`ifdef ARB_ROUND_ROBIN_EN
        if (win == 1) favour = 2;
        else if (win == 2) favour = 1;
`endif
      end
    end
    exp_ready = e_ready;
  endtask

  task automatic apply_stimulus(input logic rst, input logic [2:0] v, input logic [2:0] we);
    reset     = rst;
    req_valid = v;
    req_we    = we;
  endtask

  task automatic sample();
    @(negedge clk);
    check_output();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random requesters honouring the hold-until-ready handshake.
  task automatic gen_random();
    for (int k = 0; k < 3; k++) begin
      if (exp_ready[k]) hold[k] = 1'b0;
      if (!hold[k] && $urandom_range(0, 2) == 0) begin
        hold[k]      = 1'b1;
        req_we[k]    = 1'($urandom_range(0, 1));
        req_addr[k]  = ($urandom_range(0, 3) == 0) ? {16'hFFFF, 16'($urandom)} : $urandom;
        req_wdata[k] = $urandom;
      end
      req_valid[k] = hold[k];
    end
    reset     = ($urandom_range(0, 63) == 0);
    mem_rdata = $urandom;
  endtask

  initial begin
    int grant_cyc;
    logic [2:0] exp_g;
    wait2 = 0; favour = 1; last_addr = '0; last_wdata = '0; exp_ready = '0;
    req_addr  = '{32'h0000_0300, 32'h0000_0200, 32'h0000_0010};
    req_wdata = '{32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    mem_rdata = 32'h0;

    // Reset with every request high: all outputs zero
    apply_stimulus(1'b1, 3'b111, 3'b000);
    sample(); tick();
    sample(); tick();

    // First post-reset cycle grants R0; its data returns next cycle
    apply_stimulus(1'b0, 3'b111, 3'b000);
    mem_rdata = 32'h5A5A_0001;
    sample();
    check("post_reset_ready", {29'd0, req_ready}, 32'd1);
    check("post_reset_rsp0", {29'd0, rsp_valid}, 32'd0);
    tick();
    apply_stimulus(1'b0, 3'b000, 3'b000);
    sample();
    check("post_reset_rsp1", {29'd0, rsp_valid}, 32'd1);
    tick();
    sample(); tick();

    // R0 read at 0x10, data 0xDEADBEEF
    req_addr[0] = 32'h0000_0010;
    mem_rdata   = 32'hDEAD_BEEF;
    apply_stimulus(1'b0, 3'b001, 3'b000);
    sample();
    check("r0rd_ready", {29'd0, req_ready}, 32'd1);
    check("r0rd_stall_c0", {31'd0, cpu_stall}, 32'd0);
    tick();
    apply_stimulus(1'b0, 3'b000, 3'b000);
    sample();
    check("r0rd_rsp", {29'd0, rsp_valid}, 32'd1);
    check("r0rd_data", rsp_rdata, 32'hDEAD_BEEF);
    check("r0rd_stall_c1", {31'd0, cpu_stall}, 32'd1);
    tick();
    sample();
    check("r0rd_stall_c2", {31'd0, cpu_stall}, 32'd0);
    tick();

    // R1 write 0x12345678 to 0x100
    req_addr[1]  = 32'h0000_0100;
    req_wdata[1] = 32'h1234_5678;
    apply_stimulus(1'b0, 3'b010, 3'b010);
    sample();
    check("r1wr_we", {31'd0, mem_we}, 32'd1);
    check("r1wr_addr", mem_addr, 32'h0000_0100);
    tick();
    apply_stimulus(1'b0, 3'b000, 3'b000);
    sample();
    check("r1wr_we_after", {31'd0, mem_we}, 32'd0);
    check("r1wr_no_rsp", {29'd0, rsp_valid}, 32'd0);
    tick();

    // R0 continuous reads with R2 waiting: R2 promoted after 15 waits
    grant_cyc = -1;
    apply_stimulus(1'b0, 3'b101, 3'b000);
    for (int i = 0; i < 40; i++) begin
      sample();
      if (exp_ready[2] && grant_cyc < 0) begin
        grant_cyc = i;
        check("starve_cpu_stall", {31'd0, cpu_stall}, 32'd1);
      end
      tick();
      if (grant_cyc >= 0) req_valid[2] = 1'b0;
    end
    check("starve_grant_cycle", grant_cyc, 32'd16);
    apply_stimulus(1'b0, 3'b000, 3'b000);
    sample(); tick();
    sample(); tick();

    // R1 and R2 continuous writes
    apply_stimulus(1'b0, 3'b110, 3'b110);
    for (int i = 0; i < 20; i++) begin
      sample();
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = (i % 2 == 0) ? 3'b010 : 3'b100;
`else
      exp_g = (i == 15) ? 3'b100 : 3'b010;
`endif
      check("r1r2_grant", {29'd0, req_ready}, {29'd0, exp_g});
      tick();
    end
    apply_stimulus(1'b0, 3'b000, 3'b000);
    sample(); tick();

    // Reset during RD_WAIT drops the pending response
    apply_stimulus(1'b0, 3'b001, 3'b000);
    sample(); tick();
    apply_stimulus(1'b1, 3'b000, 3'b000);
    sample();
    check("rst_rdwait_rsp", {29'd0, rsp_valid}, 32'd0);
    tick();
    apply_stimulus(1'b0, 3'b001, 3'b000);
    sample();
    check("rst_rdwait_idle_rsp", {29'd0, rsp_valid}, 32'd0);
    check("rst_rdwait_idle_ready", {29'd0, req_ready}, 32'd1);
    tick();
    apply_stimulus(1'b0, 3'b000, 3'b000);
    sample(); tick();

    // Randomized traffic
    for (int k = 0; k < 3; k++) hold[k] = 1'b0;
    exp_ready = '0;
    for (int i = 0; i < 600; i++) begin
      gen_random();
      sample();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
